freq_sweep_ctrl: RTL and testbench

Sequencer that drives the slow-clock divider's frequency configuration for swept-tone output. It steps a frequency from F_START toward F_STOP in F_STEP increments and holds each point for DWELL clock cycles. For each point it computes the divider threshold CLK_HZ/(2*FREQ) with a multicycle divider, so the downstream divider needs no combinational division. It sits between the front-panel/UART configuration registers and the slow-clock generator.

---
 rtl/freq_sweep_ctrl_if.sv | 32 +++
 rtl/freq_sweep_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/freq_sweep_ctrl_if.sv
// Configuration/status bundle between the sweep controller
// and its register front end / slow-clock divider.
interface freq_sweep_ctrl_if #(
  parameter int W = 32
);
  logic         START;
  logic         ABORT;
  logic [1:0]   MODE;
  logic [W-1:0] F_START;
  logic [W-1:0] F_STOP;
  logic [W-1:0] F_STEP;
  logic [W-1:0] DWELL;
  logic [W-1:0] FREQ;
  logic [W-1:0] THRESHOLD;
  logic         CFG_VALID;
  logic         BUSY;
  logic         DONE;

  modport master (
    output START, ABORT, MODE,
    output F_START, F_STOP, F_STEP, DWELL,
    input  FREQ, THRESHOLD,
    input  CFG_VALID, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, MODE,
    input  F_START, F_STOP, F_STEP, DWELL,
    output FREQ, THRESHOLD,
    output CFG_VALID, BUSY, DONE
  );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep sequencer: steps FREQ between two endpoints and
// computes CLK_HZ/(2*FREQ) with a fixed-latency restoring divider.
module freq_sweep_ctrl #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int          W      = 32
) (
  input logic              CLK,
  input logic              RST,
  freq_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_CALC, S_DWELL, S_STEP
  } state_t;

  localparam int          CW  = $clog2(W + 1);
  localparam logic [W-1:0] DVD = W'(CLK_HZ);

  state_t       state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [W-1:0] fs_q, fs_d;
  logic [W-1:0] fe_q, fe_d;
  logic [W-1:0] st_q, st_d;
  logic [W-1:0] dw_q, dw_d;
  logic         up_q, up_d;
  logic [W-1:0] cand_q, cand_d;
  logic [W:0]   rem_q, rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] dcnt_q, dcnt_d;
  logic [W-1:0] freq_q, freq_d;
  logic [W-1:0] thr_q, thr_d;
  logic         cfg_q, cfg_d;

  logic [W:0]   dvs;
  logic [W+1:0] rsh;
  logic         ge;
  logic [W-1:0] hi, lo, tgt;
  logic         at_end;
  logic         single;
  logic         fin;

  // Clamped step toward tgt; sum/difference kept wide so it never wraps.
  function automatic logic [W-1:0] step_fn(
    input logic [W-1:0] cur,
    input logic [W-1:0] stp,
    input logic [W-1:0] lim,
    input logic         up
  );
    logic [W:0] s;
    s = {1'b0, cur} + {1'b0, stp};
    if (up) begin
      step_fn = (s > {1'b0, lim}) ? lim : s[W-1:0];
    end else if (cur < stp || (cur - stp) < lim) begin
      step_fn = lim;
    end else begin
      step_fn = cur - stp;
    end
  endfunction

  // Divider datapath and endpoint decode shared by the FSM.
  always_comb begin
    dvs    = {cand_q, 1'b0};
    rsh    = {rem_q, quo_q[W-1]};
    ge     = rsh >= {1'b0, dvs};
    hi     = (fe_q >= fs_q) ? fe_q : fs_q;
    lo     = (fe_q >= fs_q) ? fs_q : fe_q;
    tgt    = up_q ? hi : lo;
    at_end = (cand_q == tgt) || (st_q == '0);
    single = (mode_q == 2'b00) || (mode_q == 2'b11);
    fin    = (state_q == S_STEP) && at_end && single;
  end

  // Next-state and datapath updates; ABORT overrides everything but IDLE.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    fs_d    = fs_q;
    fe_d    = fe_q;
    st_d    = st_q;
    dw_d    = dw_q;
    up_d    = up_q;
    cand_d  = cand_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    freq_d  = freq_q;
    thr_d   = thr_q;
    cfg_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START && !bus.ABORT) begin
          mode_d  = bus.MODE;
          fs_d    = bus.F_START;
          fe_d    = bus.F_STOP;
          st_d    = bus.F_STEP;
          dw_d    = bus.DWELL;
          up_d    = bus.F_STOP >= bus.F_START;
          cand_d  = bus.F_START;
          rem_d   = '0;
          quo_d   = DVD;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rem_d = (W+1)'(ge ? rsh - {1'b0, dvs} : rsh);
        quo_d = {quo_q[W-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          freq_d  = cand_q;
          thr_d   = (cand_q == '0) ? '0 : {quo_q[W-2:0], ge};
          cfg_d   = 1'b1;
          dcnt_d  = (dw_q == '0) ? '0 : dw_q - 1'b1;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (dcnt_q == '0) begin
          state_d = S_STEP;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      S_STEP: begin
        rem_d   = '0;
        quo_d   = DVD;
        cnt_d   = '0;
        state_d = S_CALC;
        if (!at_end) begin
          cand_d = step_fn(cand_q, st_q, tgt, up_q);
        end else if (single) begin
          state_d = S_IDLE;
        end else if (mode_q == 2'b01) begin
          cand_d = fs_q;
        end else begin
          up_d   = ~up_q;
          cand_d = step_fn(cand_q, st_q, up_q ? lo : hi, ~up_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      freq_d  = freq_q;
      thr_d   = thr_q;
      cfg_d   = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      fs_q    <= '0;
      fe_q    <= '0;
      st_q    <= '0;
      dw_q    <= '0;
      up_q    <= 1'b0;
      cand_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      freq_q  <= '0;
      thr_q   <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      st_q    <= st_d;
      dw_q    <= dw_d;
      up_q    <= up_d;
      cand_q  <= cand_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      freq_q  <= freq_d;
      thr_q   <= thr_d;
      cfg_q   <= cfg_d;
    end
  end

  assign bus.FREQ      = freq_q;
  assign bus.THRESHOLD = thr_q;
  assign bus.CFG_VALID = cfg_q;
  assign bus.BUSY      = (state_q != S_IDLE) && !fin;
  assign bus.DONE      = fin && !bus.ABORT;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: table of sweeps checked through a
// scoreboard of expected config updates, plus handshake/reset cases.
module tb_freq_sweep_ctrl;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  freq_sweep_ctrl_if #(.W(32)) bus ();

  freq_sweep_ctrl #(
    .CLK_HZ(100000000),
    .W(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] fs;
    logic [31:0] fe;
    logic [31:0] st;
    logic [31:0] dw;
    int          fofs;
    int          n;
    bit          done;
  } vec_t;

  typedef struct {
    logic [31:0] f;
    logic [31:0] thr;
    int          t;
  } exp_t;

  vec_t        vt [0:7];
  logic [31:0] fl [0:23];
  exp_t        sb [$];
  int          nerr = 0;
  int          nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] ref_thr(input logic [31:0] f);
    longint unsigned ff;
    ff = 64'(f);
    if (f == 32'd0) return 32'd0;
    return 32'(64'd100000000 / (2 * ff));
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet(input string nm, input int cyc);
    int ev;
    ev = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (bus.CFG_VALID || bus.DONE) ev++;
    end
    chk(nm, 32'(ev), 32'd0);
  endtask

  task automatic run_case(input int ci);
    vec_t        v;
    exp_t        e;
    int          dp, t, last_t, budget;
    bit          dseen;
    logic [31:0] lastf;
    v  = vt[ci];
    dp = (v.dw == 0) ? 1 : int'(v.dw);
    bus.MODE    = v.mode;
    bus.F_START = v.fs;
    bus.F_STOP  = v.fe;
    bus.F_STEP  = v.st;
    bus.DWELL   = v.dw;
    bus.START   = 1'b1;
    tick();
    bus.START   = 1'b0;
    bus.MODE    = 2'($urandom_range(0, 3));
    bus.F_START = $urandom;
    bus.F_STOP  = $urandom;
    bus.F_STEP  = $urandom;
    bus.DWELL   = $urandom;
    for (int p = 0; p < v.n; p++) begin
      e.f   = fl[v.fofs + p];
      e.thr = ref_thr(e.f);
      e.t   = 32 + p * (dp + 33);
      sb.push_back(e);
    end
    last_t = 32 + (v.n - 1) * (dp + 33);
    lastf  = fl[v.fofs + v.n - 1];
    budget = last_t + dp + 10;
    t      = 0;
    dseen  = 1'b0;
    while (t < budget && !(v.done ? dseen : sb.size() == 0)) begin
      tick();
      t++;
      if (t == 5) bus.START = 1'b1;
      if (t == 6) bus.START = 1'b0;
      if (bus.CFG_VALID) begin
        if (sb.size() == 0) begin
          chk($sformatf("c%0d_extra_cfg", ci), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk($sformatf("c%0d_freq", ci), bus.FREQ, e.f);
          chk($sformatf("c%0d_thr", ci), bus.THRESHOLD, e.thr);
          chk($sformatf("c%0d_cfg_time", ci), 32'(t), 32'(e.t));
          chk($sformatf("c%0d_busy_cfg", ci), 32'(bus.BUSY), 32'd1);
        end
      end
      if (bus.DONE) begin
        dseen = 1'b1;
        chk($sformatf("c%0d_done_allowed", ci), 32'(v.done), 32'd1);
        chk($sformatf("c%0d_done_time", ci), 32'(t),
            32'(last_t + dp));
        chk($sformatf("c%0d_busy_done", ci), 32'(bus.BUSY), 32'd0);
      end
    end
    chk($sformatf("c%0d_pending", ci), 32'(sb.size()), 32'd0);
    sb.delete();
    if (v.done) begin
      chk($sformatf("c%0d_done_seen", ci), 32'(dseen), 32'd1);
      tick();
      chk($sformatf("c%0d_busy_after", ci), 32'(bus.BUSY), 32'd0);
      chk($sformatf("c%0d_freq_hold", ci), bus.FREQ, lastf);
    end else begin
      tick();
      tick();
      bus.ABORT = 1'b1;
      tick();
      bus.ABORT = 1'b0;
      chk($sformatf("c%0d_abort_busy", ci), 32'(bus.BUSY), 32'd0);
      chk($sformatf("c%0d_abort_done", ci), 32'(bus.DONE), 32'd0);
      chk($sformatf("c%0d_abort_freq", ci), bus.FREQ, lastf);
      chk($sformatf("c%0d_abort_thr", ci), bus.THRESHOLD,
          ref_thr(lastf));
      quiet($sformatf("c%0d_abort_quiet", ci), 40);
    end
  endtask

  initial begin
    vt[0] = '{2'b00, 32'd1000, 32'd3000, 32'd1000, 32'd10, 0, 3, 1'b1};
    vt[1] = '{2'b00, 32'd3000, 32'd500, 32'd1000, 32'd5, 3, 4, 1'b1};
    vt[2] = '{2'b00, 32'd1000, 32'd2500, 32'd1000, 32'd3, 7, 3, 1'b1};
    vt[3] = '{2'b10, 32'd1, 32'd3, 32'd1, 32'd2, 10, 6, 1'b0};
    vt[4] = '{2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 16, 1, 1'b1};
    vt[5] = '{2'b00, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'h100, 32'd4,
              17, 1, 1'b1};
    vt[6] = '{2'b01, 32'd10, 32'd30, 32'd10, 32'd1, 18, 5, 1'b0};
    vt[7] = '{2'b11, 32'd500, 32'd100, 32'd0, 32'd2, 23, 1, 1'b1};
    fl = '{32'd1000, 32'd2000, 32'd3000,
           32'd3000, 32'd2000, 32'd1000, 32'd500,
           32'd1000, 32'd2000, 32'd2500,
           32'd1, 32'd2, 32'd3, 32'd2, 32'd1, 32'd2,
           32'd0,
           32'hFFFFFFF0,
           32'd10, 32'd20, 32'd30, 32'd10, 32'd20,
           32'd500};

    RST         = 1'b1;
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    bus.MODE    = 2'b00;
    bus.F_START = '0;
    bus.F_STOP  = '0;
    bus.F_STEP  = '0;
    bus.DWELL   = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_freq", bus.FREQ, 32'd0);
    chk("rst_thr", bus.THRESHOLD, 32'd0);
    chk("rst_cfg", 32'(bus.CFG_VALID), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_case(i);
      tick();
    end

    bus.F_START = 32'd1000;
    bus.F_STOP  = 32'd2000;
    bus.F_STEP  = 32'd1000;
    bus.DWELL   = 32'd1;
    bus.START   = 1'b1;
    bus.ABORT   = 1'b1;
    tick();
    bus.START   = 1'b0;
    bus.ABORT   = 1'b0;
    chk("start_abort_busy", 32'(bus.BUSY), 32'd0);
    quiet("start_abort_quiet", 40);

    bus.MODE    = 2'b00;
    bus.F_START = 32'd1000;
    bus.F_STOP  = 32'd3000;
    bus.F_STEP  = 32'd1000;
    bus.DWELL   = 32'd10;
    bus.START   = 1'b1;
    tick();
    bus.START   = 1'b0;
    chk("pre_rst_busy", 32'(bus.BUSY), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_freq", bus.FREQ, 32'd0);
    chk("midrst_thr", bus.THRESHOLD, 32'd0);
    chk("midrst_cfg", 32'(bus.CFG_VALID), 32'd0);
    chk("midrst_busy", 32'(bus.BUSY), 32'd0);
    chk("midrst_done", 32'(bus.DONE), 32'd0);
    quiet("midrst_quiet", 40);

    run_case(0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
